// File: rtl/spi_flash_read_seq_if.sv
// Register-port bus between the read sequencer (master) and the SPI interface block (slave).
interface spi_flash_read_seq_if;
    logic [1:0] bus2ip_addr;
    logic [8:0] bus2ip_data;
    logic       bus2ip_wr;
    logic       bus2ip_rd;
    logic [7:0] ip2bus_data;
    logic       ip2bus_wrack;
    logic       ip2bus_rdack;

    modport master (
        output bus2ip_addr,
        output bus2ip_data,
        output bus2ip_wr,
        output bus2ip_rd,
        input  ip2bus_data,
        input  ip2bus_wrack,
        input  ip2bus_rdack
    );

    modport slave (
        input  bus2ip_addr,
        input  bus2ip_data,
        input  bus2ip_wr,
        input  bus2ip_rd,
        output ip2bus_data,
        output ip2bus_wrack,
        output ip2bus_rdack
    );
endinterface

// File: rtl/spi_flash_read_seq.sv
// Serial-flash READ (0x03) sequencer: drives the SPI block's register port and
// streams the returned payload bytes out on a valid/ready interface.
module spi_flash_read_seq #(
    parameter logic [1:0]  FREQ    = 2'b00,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rd_byte,
    output logic        rd_valid,
    input  logic        rd_ready,
    spi_flash_read_seq_if.master bus
);
    localparam int unsigned WD_W      = $clog2(TIMEOUT) + 1;
    localparam int unsigned IDX_W     = 17;
    localparam int unsigned HDR_BYTES = 4;
    localparam logic [1:0]  REG_CMD   = 2'd0;
    localparam logic [1:0]  REG_STAT  = 2'd1;
    localparam logic [1:0]  REG_TX    = 2'd2;
    localparam logic [1:0]  REG_RX    = 2'd3;
    localparam logic [7:0]  CMD_READ  = 8'h03;

    typedef enum logic [2:0] {IDLE, CFG, TXW, POLL, RXR, EMIT, GAP, FIN} state_t;

    state_t             state_q, state_d;
    state_t             gap_tgt_q, gap_tgt_d;
    logic               poll_rpt_q, poll_rpt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [23:0]        addr_q, addr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         rd_byte_q, rd_byte_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [1:0]         reg_q, reg_d;
    logic [8:0]         wdata_q, wdata_d;
    logic               abort;
    logic               wd_expired;

    // TX FIFO word for frame byte k; bit 8 closes the chip-select frame.
    function automatic logic [8:0] frame_word(input logic [IDX_W-1:0] k,
                                              input logic [IDX_W-1:0] last,
                                              input logic [23:0]      a);
        logic [7:0] b;
        if (k == IDX_W'(0))      b = CMD_READ;
        else if (k == IDX_W'(1)) b = a[23:16];
        else if (k == IDX_W'(2)) b = a[15:8];
        else if (k == IDX_W'(3)) b = a[7:0];
        else                     b = 8'h00;
        return {(k == last), b};
    endfunction

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gap_tgt_q  <= TXW;
            poll_rpt_q <= 1'b0;
            idx_q      <= '0;
            last_q     <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_byte_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            reg_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gap_tgt_q  <= gap_tgt_d;
            poll_rpt_q <= poll_rpt_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_byte_q  <= rd_byte_d;
            rd_valid_q <= rd_valid_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state and next-output logic; every bus access is followed by a strobe-free GAP.
    always_comb begin
        state_d    = state_q;
        gap_tgt_d  = gap_tgt_q;
        poll_rpt_d = poll_rpt_q;
        idx_d      = idx_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rd_byte_d  = rd_byte_q;
        rd_valid_d = rd_valid_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        abort      = 1'b0;
        wd_expired = (wd_q >= WD_W'(TIMEOUT - 1));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = addr;
                        last_d  = IDX_W'(len) + IDX_W'(HDR_BYTES - 1);
                        idx_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        wr_d    = 1'b1;
                        reg_d   = REG_CMD;
                        wdata_d = {7'b0, FREQ};
                        wd_d    = '0;
                        state_d = CFG;
                    end
                end
            end
            CFG: begin
                if (bus.ip2bus_wrack) begin
                    wr_d      = 1'b0;
                    gap_tgt_d = TXW;
                    state_d   = GAP;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            TXW: begin
                if (bus.ip2bus_wrack) begin
                    wr_d       = 1'b0;
                    gap_tgt_d  = POLL;
                    poll_rpt_d = 1'b0;
                    state_d    = GAP;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            POLL: begin
                if (bus.ip2bus_rdack) begin
                    rd_d    = 1'b0;
                    state_d = GAP;
                    if (bus.ip2bus_data[0]) begin
                        gap_tgt_d  = POLL;
                        poll_rpt_d = 1'b1;
                    end else begin
                        gap_tgt_d = RXR;
                    end
                end else if (wd_expired) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RXR: begin
                if (bus.ip2bus_rdack) begin
                    rd_d = 1'b0;
                    if (idx_q < IDX_W'(HDR_BYTES)) begin
                        idx_d     = idx_q + IDX_W'(1);
                        gap_tgt_d = TXW;
                        state_d   = GAP;
                    end else begin
                        rd_byte_d  = bus.ip2bus_data;
                        rd_valid_d = 1'b1;
                        state_d    = EMIT;
                    end
                end else if (wd_expired) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            EMIT: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (idx_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        wr_d    = 1'b1;
                        reg_d   = REG_TX;
                        wdata_d = frame_word(idx_d, last_q, addr_q);
                        wd_d    = '0;
                        state_d = TXW;
                    end
                end
            end
            GAP: begin
                state_d = gap_tgt_q;
                unique case (gap_tgt_q)
                    TXW: begin
                        wr_d    = 1'b1;
                        reg_d   = REG_TX;
                        wdata_d = frame_word(idx_q, last_q, addr_q);
                        wd_d    = '0;
                    end
                    POLL: begin
                        rd_d  = 1'b1;
                        reg_d = REG_STAT;
                        // The watchdog spans the whole polling sequence, not each poll.
                        if (!poll_rpt_q)     wd_d  = '0;
                        else if (wd_expired) abort = 1'b1;
                        else                 wd_d  = wd_q + WD_W'(1);
                    end
                    RXR: begin
                        rd_d  = 1'b1;
                        reg_d = REG_RX;
                        wd_d  = '0;
                    end
                    default: begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                wr_d    = 1'b0;
                rd_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Watchdog abort: drop strobes and finish with an error.
        if (abort) begin
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FIN;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign rd_byte         = rd_byte_q;
    assign rd_valid        = rd_valid_q;
    assign bus.bus2ip_wr   = wr_q;
    assign bus.bus2ip_rd   = rd_q;
    assign bus.bus2ip_addr = reg_q;
    assign bus.bus2ip_data = wdata_q;
endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq with a register-port model of the SPI block.
`timescale 1ns/1ps
module tb_spi_flash_read_seq;
    localparam int unsigned TIMEOUT = 1024;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic [23:0] addr     = '0;
    logic [15:0] len      = '0;
    logic        rd_ready = 1'b0;
    logic        busy, done, err, rd_valid;
    logic [7:0]  rd_byte;

    spi_flash_read_seq_if bus ();

    spi_flash_read_seq #(.FREQ(2'b00), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rd_byte  (rd_byte),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model knobs, written only by the stimulus process.
    int         wr_hold_cyc = 0;
    int         empty_polls = 0;
    bit         rx_noack    = 1'b0;
    int         rx_base     = 0;
    logic [7:0] rx_q [16];

    // Model state and logs, written only by the model process.
    int         wr_wait = 0, poll_cnt = 0;
    int         tx_cnt = 0, cfg_cnt = 0, stat_reads = 0, rx_reads = 0;
    int         out_cnt = 0, strb_cyc = 0, viol = 0, done_cnt = 0;
    logic [8:0] cfg_last = '0;
    logic [8:0] tx_log [64];
    logic [7:0] out_log [64];
    logic       p_wr = 1'b0, p_rd = 1'b0, p_wrack = 1'b0, p_rdack = 1'b0;
    logic [1:0] p_addr = '0;
    logic [8:0] p_data = '0;

    initial begin
        bus.ip2bus_wrack = 1'b0;
        bus.ip2bus_rdack = 1'b0;
        bus.ip2bus_data  = 8'h00;
    end

    // SPI block register model plus bus-protocol and output monitors.
    always @(posedge clk) begin
        if (rst) begin
            bus.ip2bus_wrack <= 1'b0;
            bus.ip2bus_rdack <= 1'b0;
            wr_wait          <= 0;
            poll_cnt         <= 0;
        end else begin
            bus.ip2bus_wrack <= 1'b0;
            bus.ip2bus_rdack <= 1'b0;
            if (bus.bus2ip_wr && !bus.ip2bus_wrack) begin
                if (bus.bus2ip_addr == 2'd2 && wr_wait < wr_hold_cyc) begin
                    wr_wait <= wr_wait + 1;
                end else begin
                    bus.ip2bus_wrack <= 1'b1;
                    wr_wait          <= 0;
                    if (bus.bus2ip_addr == 2'd2) begin
                        tx_log[tx_cnt % 64] <= bus.bus2ip_data;
                        tx_cnt   <= tx_cnt + 1;
                        poll_cnt <= 0;
                    end else if (bus.bus2ip_addr == 2'd0) begin
                        cfg_cnt  <= cfg_cnt + 1;
                        cfg_last <= bus.bus2ip_data;
                    end
                end
            end
            if (bus.bus2ip_rd && !bus.ip2bus_rdack) begin
                if (bus.bus2ip_addr == 2'd1) begin
                    bus.ip2bus_rdack <= 1'b1;
                    stat_reads       <= stat_reads + 1;
                    if (poll_cnt < empty_polls) begin
                        bus.ip2bus_data <= 8'h05;
                        poll_cnt        <= poll_cnt + 1;
                    end else begin
                        bus.ip2bus_data <= 8'h04;
                    end
                end else if (bus.bus2ip_addr == 2'd3 && !rx_noack) begin
                    bus.ip2bus_rdack <= 1'b1;
                    bus.ip2bus_data  <= rx_q[(rx_reads - rx_base) % 16];
                    rx_reads         <= rx_reads + 1;
                end
            end
        end
        if (bus.bus2ip_wr || bus.bus2ip_rd) strb_cyc <= strb_cyc + 1;
        if ((bus.bus2ip_wr && bus.bus2ip_rd) ||
            (p_wr && p_wrack && bus.bus2ip_wr) ||
            (p_rd && p_rdack && bus.bus2ip_rd) ||
            (p_wr && !p_wrack && bus.bus2ip_wr &&
             (bus.bus2ip_addr != p_addr || bus.bus2ip_data != p_data)) ||
            (p_rd && !p_rdack && bus.bus2ip_rd && bus.bus2ip_addr != p_addr))
            viol <= viol + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (rd_valid && rd_ready) begin
            out_log[out_cnt % 64] <= rd_byte;
            out_cnt <= out_cnt + 1;
        end
        p_wr    <= bus.bus2ip_wr;
        p_rd    <= bus.bus2ip_rd;
        p_wrack <= bus.ip2bus_wrack;
        p_rdack <= bus.ip2bus_rdack;
        p_addr  <= bus.bus2ip_addr;
        p_data  <= bus.bus2ip_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_outs"},
              32'({busy, done, err, rd_valid, rd_byte, bus.bus2ip_wr, bus.bus2ip_rd,
                   bus.bus2ip_addr, bus.bus2ip_data}), 32'd0);
    endtask

    task automatic set_rx(input logic [7:0] p0, input logic [7:0] p1);
        for (int i = 0; i < 16; i++) rx_q[i] = 8'hFF;
        rx_q[4] = p0;
        rx_q[5] = p1;
        rx_base = rx_reads;
    endtask

    task automatic do_start(input logic [23:0] a, input logic [15:0] n);
        @(negedge clk);
        addr  = a;
        len   = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    logic [8:0] exp_tx [6];
    int t0, o0, d0, s0, r0, c0, cyc, held, found;

    initial begin
        for (int i = 0; i < 16; i++) rx_q[i] = 8'hFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_rst_vals("reset");
        rst      = 1'b0;
        rd_ready = 1'b1;

        // Basic two-byte read with 1-cycle acks.
        set_rx(8'hA5, 8'h3C);
        t0 = tx_cnt; o0 = out_cnt; d0 = done_cnt; c0 = cfg_cnt;
        do_start(24'h012345, 16'd2);
        check("t1_busy_rise", 32'(busy), 32'd1);
        check("t1_cfg_strobe", 32'({bus.bus2ip_wr, bus.bus2ip_rd, bus.bus2ip_addr, bus.bus2ip_data}),
              32'({1'b1, 1'b0, 2'd0, 9'h000}));
        wait_done("t1", 2000, cyc);
        check("t1_err", 32'(err), 32'd0);
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);
        check("t1_cfg_cnt", 32'(cfg_cnt - c0), 32'd1);
        check("t1_cfg_val", 32'(cfg_last), 32'h000);
        exp_tx = '{9'h003, 9'h001, 9'h023, 9'h045, 9'h000, 9'h100};
        check("t1_tx_count", 32'(tx_cnt - t0), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t1_tx%0d", i), 32'(tx_log[(t0 + i) % 64]), 32'(exp_tx[i]));
        check("t1_out_count", 32'(out_cnt - o0), 32'd2);
        check("t1_out0", 32'(out_log[o0 % 64]), 32'hA5);
        check("t1_out1", 32'(out_log[(o0 + 1) % 64]), 32'h3C);

        // len == 0 is a no-op with a done pulse one cycle later.
        s0 = strb_cyc; d0 = done_cnt;
        do_start(24'h111111, 16'd0);
        check("t2_done_pulse", 32'({done, busy}), 32'({1'b1, 1'b0}));
        @(negedge clk);
        check("t2_done_drop", 32'({done, busy}), 32'd0);
        check("t2_no_strobe", 32'(strb_cyc - s0), 32'd0);
        check("t2_done_once", 32'(done_cnt - d0), 32'd1);

        // Slow TX acks and long rx_empty polling.
        wr_hold_cyc = 20; empty_polls = 17;
        set_rx(8'h5A, 8'h00);
        t0 = tx_cnt; o0 = out_cnt; s0 = stat_reads;
        do_start(24'hABCDEF, 16'd1);
        wait_done("t3", 3000, cyc);
        check("t3_err", 32'(err), 32'd0);
        exp_tx = '{9'h003, 9'h0AB, 9'h0CD, 9'h0EF, 9'h100, 9'h000};
        check("t3_tx_count", 32'(tx_cnt - t0), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t3_tx%0d", i), 32'(tx_log[(t0 + i) % 64]), 32'(exp_tx[i]));
        check("t3_polls", 32'(stat_reads - s0), 32'd90);
        check("t3_out0", 32'(out_log[o0 % 64]), 32'h5A);
        wr_hold_cyc = 0; empty_polls = 0;

        // Consumer stalls on the first payload byte.
        rd_ready = 1'b0;
        set_rx(8'h11, 8'h22);
        o0 = out_cnt;
        do_start(24'h000100, 16'd2);
        cyc = 0;
        while (!rd_valid && cyc < 500) begin @(negedge clk); cyc++; end
        check("t4_valid_rise", 32'(rd_valid), 32'd1);
        r0 = rx_reads; s0 = strb_cyc; held = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_valid && rd_byte == 8'h11) held++;
        end
        check("t4_held", 32'(held), 32'd100);
        check("t4_no_rx_read", 32'(rx_reads - r0), 32'd0);
        check("t4_no_strobe", 32'(strb_cyc - s0), 32'd0);
        rd_ready = 1'b1;
        wait_done("t4", 2000, cyc);
        check("t4_err", 32'(err), 32'd0);
        @(negedge clk);
        check("t4_out0", 32'(out_log[o0 % 64]), 32'h11);
        check("t4_out1", 32'(out_log[(o0 + 1) % 64]), 32'h22);

        // RX read never acknowledged: watchdog abort, then a clean retry.
        rx_noack = 1'b1;
        set_rx(8'h77, 8'h00);
        do_start(24'h000200, 16'd1);
        wait_done("t5", 1500, cyc);
        check("t5_err", 32'(err), 32'd1);
        check("t5_strobes_low", 32'({bus.bus2ip_wr, bus.bus2ip_rd}), 32'd0);
        check("t5_waited", 32'(cyc >= int'(TIMEOUT)), 32'd1);
        rx_noack = 1'b0;
        set_rx(8'h77, 8'h00);
        o0 = out_cnt;
        do_start(24'h000200, 16'd1);
        check("t5_err_clear", 32'(err), 32'd0);
        wait_done("t5b", 2000, cyc);
        check("t5b_err", 32'(err), 32'd0);
        @(negedge clk);
        check("t5b_out0", 32'(out_log[o0 % 64]), 32'h77);

        // Reset while polling status for byte 3, then a fresh transaction.
        set_rx(8'h99, 8'h00);
        t0 = tx_cnt; found = 0; cyc = 0;
        do_start(24'h345678, 16'd1);
        while (found == 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bus.bus2ip_rd && bus.bus2ip_addr == 2'd1 && tx_cnt - t0 == 4) found = 1;
        end
        check("t6_poll_b3", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_rst_vals("t6_rst");
        rst = 1'b0;
        set_rx(8'hC3, 8'h00);
        t0 = tx_cnt; o0 = out_cnt;
        do_start(24'h000010, 16'd1);
        check("t6_cfg_strobe", 32'({busy, bus.bus2ip_wr, bus.bus2ip_addr}), 32'({1'b1, 1'b1, 2'd0}));
        wait_done("t6", 2000, cyc);
        check("t6_err", 32'(err), 32'd0);
        @(negedge clk);
        check("t6_tx_count", 32'(tx_cnt - t0), 32'd5);
        check("t6_tx_last", 32'(tx_log[(t0 + 4) % 64]), 32'h100);
        check("t6_out0", 32'(out_log[o0 % 64]), 32'hC3);

        check("bus_protocol", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
